// File: rtl/pio_irq_gen2_pkg.sv
//----------------------------------------------------------------------------
// Module : pio_irq_gen2_pkg
// Brief  : Register map, reset defaults and bus helper for the PIO with IRQ
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package pio_irq_gen2_pkg;

    localparam int         c_addr_w      = 3;

    localparam logic [2:0] c_reg_data    = 3'd0;
    localparam logic [2:0] c_reg_dir     = 3'd1;
    localparam logic [2:0] c_reg_irqmask = 3'd2;
    localparam logic [2:0] c_reg_edgecap = 3'd3;
    localparam logic [2:0] c_reg_outset  = 3'd4;
    localparam logic [2:0] c_reg_outclr  = 3'd5;
    localparam logic [2:0] c_reg_rise_en = 3'd6;
    localparam logic [2:0] c_reg_fall_en = 3'd7;

    // Per-bit reset value, replicated to the port width by the top level
    localparam logic       c_rise_en_rst = 1'b1;
    localparam logic       c_fall_en_rst = 1'b0;

    // Avalon-MM write qualifier
    function automatic logic wr_strobe(input logic cs, input logic wr_n);
        return cs & ~wr_n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pio_edge_sync.sv
//----------------------------------------------------------------------------
// Module : pio_edge_sync
// Brief  : One-channel input synchroniser with history flop and edge detect.
//          While the chain refills after reset the history flop loads the
//          same value as s, so a level present across reset is not an edge.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module pio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_s_d;

    // Synchroniser chain, fill tracker and history flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_fill <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            // Until the first post-reset sample reaches s, track s's next value
            r_s_d  <= r_fill[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1]
                                            : r_sync[SYNC_STAGES-2];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = s & ~r_s_d;
    assign fall = ~s & r_s_d;

endmodule

`default_nettype wire

// File: rtl/pio_irq_gen2.sv
//----------------------------------------------------------------------------
// Module : pio_irq_gen2
// Brief  : Parametrised GPIO port with direction, atomic set/clear, per-bit
//          edge selection, write-1-to-clear capture and level interrupt on an
//          Avalon-MM slave with one-cycle registered read.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module pio_irq_gen2
    import pio_irq_gen2_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_addr_w-1:0] address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    oe,
    output logic                irq
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr           = wr_strobe(chipselect, write_n);
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .pin   (in_port[i]),
            .s     (w_s[i]),
            .rise  (w_rise[i]),
            .fall  (w_fall[i])
        );
    end

    assign w_ev  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr = (w_wr && address == c_reg_edgecap) ? w_wdata : '0;

    // Writable control registers; only the addressed one changes per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= OUT_RESET;
            r_dir     <= '0;
            r_mask    <= '0;
            r_rise_en <= {WIDTH{c_rise_en_rst}};
            r_fall_en <= {WIDTH{c_fall_en_rst}};
        end else if (w_wr) begin
            case (address)
                c_reg_data:    r_out     <= w_wdata;
                c_reg_dir:     r_dir     <= w_wdata;
                c_reg_irqmask: r_mask    <= w_wdata;
                c_reg_outset:  r_out     <= r_out | w_wdata;
                c_reg_outclr:  r_out     <= r_out & ~w_wdata;
                c_reg_rise_en: r_rise_en <= w_wdata;
                c_reg_fall_en: r_fall_en <= w_wdata;
                default:       ;
            endcase
        end
    end

    // Edge capture: clear first, then OR in new events so none are lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_ev;
        end
    end

    // Read mux; write-only strobes and unused upper bits read as zero
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_reg_data:    w_rd_mux[WIDTH-1:0] = w_s;
            c_reg_dir:     w_rd_mux[WIDTH-1:0] = r_dir;
            c_reg_irqmask: w_rd_mux[WIDTH-1:0] = r_mask;
            c_reg_edgecap: w_rd_mux[WIDTH-1:0] = r_edgecap;
            c_reg_rise_en: w_rd_mux[WIDTH-1:0] = r_rise_en;
            c_reg_fall_en: w_rd_mux[WIDTH-1:0] = r_fall_en;
            default:       w_rd_mux = '0;
        endcase
    end

    // Read data registered every cycle, independent of chipselect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;
    assign oe       = r_dir;
    assign irq      = |(r_edgecap & r_mask);

endmodule

`default_nettype wire
